// File: rtl/sid_init_sequencer.sv
// -----------------------------------------------------------------------------
// sid_init_sequencer
//
// Walks an init ROM from entry 0 and issues each {register, data} entry as a
// SID register write. Entry 1F:FF ends the sequence. A pointer advance from
// entry 255 also ends it, so entry 0 is never re-executed.
//
// Optional feature (compile-time macro SIDSEQ_DELAY_CMD_EN):
//   When defined, an entry 1F:N with N != FF is a delay command. It waits
//   N*DELAY_UNIT clocks and issues no SID write. When undefined, such an entry
//   is written to the SID like any other, and the DELAY state does not exist.
//
// Parameters:
//   GAP_CYCLES  idle clocks after each accepted SID write (0 = none)
//   DELAY_UNIT  clocks per count of a delay entry (delay builds only)
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        one-cycle request to run the sequence from entry 0
//   rom_addr     entry index presented to the init ROM
//   rom_read_en  ROM read strobe, high only in FETCH
//   rom_reg_in   ROM register field, valid the cycle after rom_read_en
//   rom_data_in  ROM data field, same timing as rom_reg_in
//   sid_addr     SID register address
//   sid_data     SID write data
//   sid_we       write request, held until accepted
//   sid_ready    write accepted on an edge where sid_we and sid_ready are high
//   busy         high in every state except IDLE and DONE
//   done         high in DONE, held until the next start
//   write_count  accepted SID writes this run, saturating at 255
// -----------------------------------------------------------------------------
module sid_init_sequencer #(
    parameter int GAP_CYCLES = 16,
    parameter int DELAY_UNIT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] rom_addr,
    output logic       rom_read_en,
    input  logic [4:0] rom_reg_in,
    input  logic [7:0] rom_data_in,
    output logic [4:0] sid_addr,
    output logic [7:0] sid_data,
    output logic       sid_we,
    input  logic       sid_ready,
    output logic       busy,
    output logic       done,
    output logic [7:0] write_count
);

    if (DELAY_UNIT < 1) begin : g_bad_delay_unit
        $error("sid_init_sequencer: DELAY_UNIT must be at least 1");
    end

    // The gap counter holds GAP_CYCLES-1 down to 0; it keeps one bit even when
    // GAP_CYCLES is 0 and the counter is never loaded.
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_WRITE,
        S_GAP,
        S_DONE
`ifdef SIDSEQ_DELAY_CMD_EN
        , S_DELAY
`endif
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_ptr;
    logic [4:0]       r_sid_addr;
    logic [7:0]       r_sid_data;
    logic [7:0]       r_write_count;
    logic [GAP_W-1:0] r_gap_cnt;

    logic w_start_run;
    logic w_load_sid;
    logic w_load_gap;
    logic w_accept;
    logic w_advance;
    logic w_is_sentinel;

`ifdef SIDSEQ_DELAY_CMD_EN
    // Longest delay is 255*DELAY_UNIT clocks; the counter holds that minus one.
    localparam int DLY_W = $clog2(255 * DELAY_UNIT);

    logic [DLY_W-1:0] r_delay_cnt;
    logic             w_load_delay;
`endif

    assign w_is_sentinel = (rom_reg_in == 5'h1F) && (rom_data_in == 8'hFF);

    // NOTE: the reset branch is asynchronous (in the sensitivity list), so
    // rst_n forces IDLE immediately, even in the middle of a write or delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_start_run  = 1'b0;
        w_load_sid   = 1'b0;
        w_load_gap   = 1'b0;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
`ifdef SIDSEQ_DELAY_CMD_EN
        w_load_delay = 1'b0;
`endif

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_start_run  = 1'b1;
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: w_state_next = S_DECODE;

            S_DECODE: begin
                if (w_is_sentinel) begin
                    w_state_next = S_DONE;
                end
`ifdef SIDSEQ_DELAY_CMD_EN
                else if (rom_reg_in == 5'h1F) begin
                    // A zero-length delay skips the DELAY state entirely.
                    if (rom_data_in == 8'h00) begin
                        w_advance = 1'b1;
                    end else begin
                        w_load_delay = 1'b1;
                        w_state_next = S_DELAY;
                    end
                end
`endif
                else begin
                    w_load_sid   = 1'b1;
                    w_state_next = S_WRITE;
                end
            end

            S_WRITE: begin
                if (sid_ready) begin
                    w_accept = 1'b1;
                    if (GAP_CYCLES > 0) begin
                        w_load_gap   = 1'b1;
                        w_state_next = S_GAP;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_advance = 1'b1;
                end
            end

`ifdef SIDSEQ_DELAY_CMD_EN
            S_DELAY: begin
                if (r_delay_cnt == '0) begin
                    w_advance = 1'b1;
                end
            end
`endif

            default: w_state_next = S_IDLE;
        endcase

        // Advancing past the last entry ends the run rather than wrapping.
        if (w_advance) begin
            w_state_next = (r_ptr == 8'hFF) ? S_DONE : S_FETCH;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register here sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr         <= 8'h00;
            r_sid_addr    <= 5'h00;
            r_sid_data    <= 8'h00;
            r_write_count <= 8'h00;
            r_gap_cnt     <= '0;
        end else begin
            if (w_start_run) begin
                r_ptr <= 8'h00;
            end else if (w_advance && (r_ptr != 8'hFF)) begin
                r_ptr <= r_ptr + 8'd1;
            end

            if (w_load_sid) begin
                r_sid_addr <= rom_reg_in;
                r_sid_data <= rom_data_in;
            end

            if (w_start_run) begin
                r_write_count <= 8'h00;
            end else if (w_accept && (r_write_count != 8'hFF)) begin
                r_write_count <= r_write_count + 8'd1;
            end

            if (w_load_gap) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
        end
    end

`ifdef SIDSEQ_DELAY_CMD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_delay_cnt <= '0;
        end else if (w_load_delay) begin
            // N*DELAY_UNIT clocks in DELAY: load N*DELAY_UNIT-1 and count to 0.
            r_delay_cnt <= DLY_W'(rom_data_in) * DLY_W'(DELAY_UNIT) - DLY_W'(1);
        end else if ((r_state == S_DELAY) && (r_delay_cnt != '0)) begin
            r_delay_cnt <= r_delay_cnt - 1'b1;
        end
    end
`endif

    assign rom_addr    = r_ptr;
    assign rom_read_en = (r_state == S_FETCH);
    assign sid_addr    = r_sid_addr;
    assign sid_data    = r_sid_data;
    assign sid_we      = (r_state == S_WRITE);
    assign busy        = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done        = (r_state == S_DONE);
    assign write_count = r_write_count;

endmodule

// File: tb/tb_sid_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sid_init_sequencer
//
// Directed bench for sid_init_sequencer (GAP_CYCLES=16, DELAY_UNIT=4). A
// behavioural ROM answers read strobes one cycle later. A monitor logs every
// accepted SID write with its cycle number. A stall helper holds sid_ready low
// for 10 clocks on the write to register 05. Expectations for delay entries
// follow SIDSEQ_DELAY_CMD_EN.
// -----------------------------------------------------------------------------
module tb_sid_init_sequencer;

    localparam int GAP = 16;
    localparam int DU  = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] rom_addr;
    logic       rom_read_en;
    logic [4:0] rom_reg_in  = 5'h00;
    logic [7:0] rom_data_in = 8'h00;
    logic [4:0] sid_addr;
    logic [7:0] sid_data;
    logic       sid_we;
    logic       sid_ready;
    logic       busy;
    logic       done;
    logic [7:0] write_count;

    logic ready_base   = 1'b1;
    logic stall_en     = 1'b0;
    logic stall_active = 1'b0;
    int   stall_cnt    = 0;
    int   stall_stable = 0;

    assign sid_ready = ready_base & ~stall_active;

    sid_init_sequencer #(
        .GAP_CYCLES (GAP),
        .DELAY_UNIT (DU)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_read_en (rom_read_en),
        .rom_reg_in  (rom_reg_in),
        .rom_data_in (rom_data_in),
        .sid_addr    (sid_addr),
        .sid_data    (sid_data),
        .sid_we      (sid_we),
        .sid_ready   (sid_ready),
        .busy        (busy),
        .done        (done),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    // Behavioural init ROM: data valid the cycle after the strobe.
    logic [4:0] rom_reg [256];
    logic [7:0] rom_dat [256];

    always @(posedge clk) begin
        if (rom_read_en) begin
            rom_reg_in  <= rom_reg[rom_addr];
            rom_data_in <= rom_dat[rom_addr];
        end
    end

    // Accepted-write log and ROM read counter.
    int         cyc     = 0;
    int         n_acc   = 0;
    int         n_reads = 0;
    logic [4:0] acc_addr [1024];
    logic [7:0] acc_data [1024];
    int         acc_cyc  [1024];

    always @(posedge clk) begin
        if (sid_we && sid_ready && (n_acc < 1024)) begin
            acc_addr[n_acc] = sid_addr;
            acc_data[n_acc] = sid_data;
            acc_cyc[n_acc]  = cyc;
            n_acc++;
        end
        if (rom_read_en) n_reads++;
        cyc++;
    end

    // Stall helper: ready low for the first 10 clocks of the write to reg 05.
    always @(negedge clk) begin
        if (!stall_en) begin
            stall_cnt    = 0;
            stall_active = 1'b0;
        end else if (sid_we && (sid_addr == 5'h05) && (stall_cnt < 10)) begin
            stall_active = 1'b1;
            stall_cnt++;
            if (sid_data == 8'h80) stall_stable++;
        end else begin
            stall_active = 1'b0;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) begin
            rom_reg[i] = 5'h00;
            rom_dat[i] = 8'h00;
        end
    endtask

    task automatic set_entry(input int idx, input logic [4:0] r, input logic [7:0] d);
        rom_reg[idx] = r;
        rom_dat[idx] = d;
    endtask

    // Start pulse: on return, the sampling edge has passed and the DUT is in FETCH.
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (!done && (i < budget)) begin
            @(negedge clk);
            i++;
        end
        check({tag, " done reached"}, done, 1);
    endtask

    logic [4:0] exp_a [6];
    logic [7:0] exp_d [6];
    int base;
    int rbase;
    int n5;
    int bad;

    initial begin
        exp_a[0] = 5'h18; exp_d[0] = 8'h04;
        exp_a[1] = 5'h00; exp_d[1] = 8'h00;
        exp_a[2] = 5'h01; exp_d[2] = 8'h20;
        exp_a[3] = 5'h05; exp_d[3] = 8'h80;
        exp_a[4] = 5'h06; exp_d[4] = 8'hF5;
        exp_a[5] = 5'h04; exp_d[5] = 8'h21;
        clear_rom();

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst sid_we", sid_we, 0);
        check("rst rom_read_en", rom_read_en, 0);
        check("rst rom_addr", rom_addr, 0);
        check("rst sid_addr", sid_addr, 0);
        check("rst sid_data", sid_data, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst write_count", write_count, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle busy", busy, 0);
        check("idle no reads", n_reads, 0);

        // ---------------- run 1: six writes, ready high ----------------
        for (int i = 0; i < 6; i++) set_entry(i, exp_a[i], exp_d[i]);
        set_entry(6, 5'h1F, 8'hFF);
        base  = n_acc;
        rbase = n_reads;
        pulse_start();
        check("r1 fetch rom_read_en", rom_read_en, 1);
        check("r1 fetch rom_addr", rom_addr, 0);
        check("r1 fetch busy", busy, 1);
        check("r1 fetch sid_we", sid_we, 0);
        @(negedge clk);
        check("r1 decode rom_read_en", rom_read_en, 0);
        check("r1 decode sid_we", sid_we, 0);
        @(negedge clk);
        check("r1 write sid_we", sid_we, 1);
        check("r1 write sid_addr", sid_addr, 5'h18);
        check("r1 write sid_data", sid_data, 8'h04);
        wait_done("r1", 2000);
        check("r1 accepts", n_acc - base, 6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("r1 w%0d addr", i), acc_addr[base + i], exp_a[i]);
            check($sformatf("r1 w%0d data", i), acc_data[base + i], exp_d[i]);
        end
        check("r1 write_count", write_count, 6);
        check("r1 busy", busy, 0);
        check("r1 sid_we", sid_we, 0);
        check("r1 reads", n_reads - rbase, 7);
        // accept, 16 gap clocks, FETCH, DECODE, then accept on first WRITE edge
        check("r1 gap spacing", acc_cyc[base + 1] - acc_cyc[base], 19);
        repeat (3) @(negedge clk);
        check("r1 done held", done, 1);

        // ---------------- run 2: restart from DONE, stalled 05:80 ----------------
        stall_en = 1'b1;
        base = n_acc;
        pulse_start();
        check("r2 done cleared", done, 0);
        check("r2 count restart", write_count, 0);
        check("r2 busy", busy, 1);
        wait_done("r2", 2000);
        stall_en = 1'b0;
        check("r2 accepts", n_acc - base, 6);
        check("r2 first addr", acc_addr[base], 5'h18);
        n5 = 0;
        for (int i = 0; i < 6; i++) if (acc_addr[base + i] == 5'h05) n5++;
        check("r2 single 05 accept", n5, 1);
        check("r2 stall stable clocks", stall_stable, 10);
        check("r2 stall spacing", acc_cyc[base + 3] - acc_cyc[base + 2], 29);
        check("r2 post-stall gap", acc_cyc[base + 4] - acc_cyc[base + 3], 19);
        check("r2 write_count", write_count, 6);

        // ---------------- run 3: 1F:0A entry, start ignored while busy ----------------
        clear_rom();
        set_entry(0, 5'h04, 8'h11);
        set_entry(1, 5'h1F, 8'h0A);
        set_entry(2, 5'h04, 8'h81);
        set_entry(3, 5'h1F, 8'hFF);
        base  = n_acc;
        rbase = n_reads;
        pulse_start();
        repeat (30) @(negedge clk);
        check("r3 busy before stray start", busy, 1);
        pulse_start();
        wait_done("r3", 2000);
        check("r3 reads", n_reads - rbase, 4);
        check("r3 first addr", acc_addr[base], 5'h04);
        check("r3 first data", acc_data[base], 8'h11);
`ifdef SIDSEQ_DELAY_CMD_EN
        check("r3 accepts", n_acc - base, 2);
        check("r3 second data", acc_data[base + 1], 8'h81);
        // 16 gap + FETCH/DECODE + 40 delay + FETCH/DECODE + accept edge
        check("r3 delay spacing", acc_cyc[base + 1] - acc_cyc[base], 61);
        check("r3 write_count", write_count, 2);

        clear_rom();
        set_entry(0, 5'h04, 8'h11);
        set_entry(1, 5'h1F, 8'h00);
        set_entry(2, 5'h04, 8'h81);
        set_entry(3, 5'h1F, 8'hFF);
        base = n_acc;
        pulse_start();
        wait_done("r3z", 2000);
        check("r3z accepts", n_acc - base, 2);
        check("r3z zero-delay spacing", acc_cyc[base + 1] - acc_cyc[base], 21);
        check("r3z write_count", write_count, 2);
`else
        check("r3 accepts", n_acc - base, 3);
        check("r3 1F write addr", acc_addr[base + 1], 5'h1F);
        check("r3 1F write data", acc_data[base + 1], 8'h0A);
        check("r3 third data", acc_data[base + 2], 8'h81);
        check("r3 spacing", acc_cyc[base + 2] - acc_cyc[base + 1], 19);
        check("r3 write_count", write_count, 3);
`endif

        // ---------------- reset while sid_we is high ----------------
        clear_rom();
        set_entry(0, 5'h0A, 8'h55);
        set_entry(1, 5'h1F, 8'hFF);
        ready_base = 1'b0;
        base = n_acc;
        pulse_start();
        begin
            int i = 0;
            while (!sid_we && (i < 10)) begin
                @(negedge clk);
                i++;
            end
        end
        check("rw sid_we before reset", sid_we, 1);
        check("rw sid_addr before reset", sid_addr, 5'h0A);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw async sid_we", sid_we, 0);
        check("rw async busy", busy, 0);
        check("rw async sid_addr", sid_addr, 0);
        check("rw async sid_data", sid_data, 0);
        check("rw async rom_addr", rom_addr, 0);
        check("rw async write_count", write_count, 0);
        check("rw async done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_base = 1'b1;
        rbase = n_reads;
        repeat (5) @(negedge clk);
        check("rw idle after release", busy, 0);
        check("rw no reads after release", n_reads - rbase, 0);
        check("rw no accept", n_acc - base, 0);

        // ---------------- no sentinel: 256 writes then DONE ----------------
        for (int i = 0; i < 256; i++) set_entry(i, 5'(i % 31), 8'(i));
        base  = n_acc;
        rbase = n_reads;
        pulse_start();
        wait_done("ns", 6000);
        check("ns accepts", n_acc - base, 256);
        check("ns reads", n_reads - rbase, 256);
        check("ns write_count saturates", write_count, 8'hFF);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if ((acc_addr[base + i] !== 5'(i % 31)) || (acc_data[base + i] !== 8'(i))) bad++;
        end
        check("ns write order", bad, 0);
        repeat (20) @(negedge clk);
        check("ns no re-execution", n_acc - base, 256);
        check("ns busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
